// File: rtl/spi_pkg.sv
// Shared types and elaboration helpers for the multi-mode SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  // Per-transfer configuration captured when start is accepted.
  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
    logic hold_cs;
  } spi_cfg_t;

  // System clocks per SCLK half period.
  function automatic int calc_half(input int clk_hz, input int spi_hz);
    return clk_hz / (2 * spi_hz);
  endfunction

  // A half period of at least two system clocks gives MISO a full cycle of margin.
  function automatic bit half_ok(input int half);
    return (half >= 2);
  endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// SCLK half-period divider: pulses tick_o every HALF enabled cycles and
// tracks whether the next SCLK edge is a leading or trailing one.
module spi_edge_gen #(
  parameter int HALF = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic shift_i,
  output logic tick_o,
  output logic lead_o
);

  localparam int DIVW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  assign tick_o = en_i && (cnt_q == DIVW'(HALF - 1));
  assign lead_o = ~phase_q;

  // Divider next state: clear when idle, wrap on tick, flip edge phase only while shifting.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick_o) begin
      cnt_d   = '0;
      phase_d = shift_i ? ~phase_q : phase_q;
    end else begin
      cnt_d   = cnt_q + DIVW'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// Multi-mode SPI master: CPOL/CPHA per transfer, MSB/LSB order, one-hot
// chip selects, CS hold for bursts and a guaranteed CS-high gap.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int  CLK_FREQ   = 50_000_000,
  parameter int  SPI_FREQ   = 1_000_000,
  parameter int  DATA_WIDTH = 8,
  parameter int  NUM_CS     = 4,
  localparam int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CSW-1:0]        cs_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  hold_cs,
  input  logic                  start,
  input  logic                  cs_release,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  ready,
  output logic                  spi_sclk,
  output logic [NUM_CS-1:0]     spi_cs_n,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int HALF  = calc_half(CLK_FREQ, SPI_FREQ);
  localparam int NEDGE = 2 * DATA_WIDTH;
  localparam int ECW   = $clog2(NEDGE + 1);

  if (!half_ok(HALF)) begin : g_half_chk
    $error("spi_master_multi: CLK_FREQ/(2*SPI_FREQ) must be at least 2");
  end
  if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_dw_chk
    $error("spi_master_multi: DATA_WIDTH must be within 2..32");
  end
  if (NUM_CS < 1 || NUM_CS > 8) begin : g_cs_chk
    $error("spi_master_multi: NUM_CS must be within 1..8");
  end

  spi_state_e            state_q, state_d;
  spi_cfg_t              cfg_q, cfg_d, cfg_in_s;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, tx_next_s;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d, rx_shift_s;
  logic [ECW-1:0]        edge_cnt_q, edge_cnt_d;
  logic                  sclk_q, sclk_d;
  logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  tick_s, lead_s, div_en_s, last_edge_s;

  // Bit presented on MOSI first for a given word and order.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  // Active-low one-hot select; an out-of-range index selects nobody.
  function automatic logic [NUM_CS-1:0] decode_cs(input logic [CSW-1:0] sel);
    logic [NUM_CS-1:0] dec;
    for (int i = 0; i < NUM_CS; i++) begin
      dec[i] = (int'(sel) == i) ? 1'b0 : 1'b1;
    end
    return dec;
  endfunction

  assign cfg_in_s    = '{cpol: cpol, cpha: cpha, lsb_first: lsb_first, hold_cs: hold_cs};
  assign tx_next_s   = cfg_q.lsb_first ? {1'b0, tx_sr_q[DATA_WIDTH-1:1]}
                                       : {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
  assign rx_shift_s  = cfg_q.lsb_first ? {spi_miso, rx_sr_q[DATA_WIDTH-1:1]}
                                       : {rx_sr_q[DATA_WIDTH-2:0], spi_miso};
  assign last_edge_s = (edge_cnt_q == ECW'(NEDGE - 1));
  assign div_en_s    = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                       (state_q == ST_TRAIL) || (state_q == ST_GAP);

  spi_edge_gen #(.HALF(HALF)) u_edge_gen (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .en_i    (div_en_s),
    .shift_i (state_q == ST_SHIFT),
    .tick_o  (tick_s),
    .lead_o  (lead_s)
  );

  // Transfer FSM: next state, shift registers and pin levels.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d      = cfg_in_s;
          tx_sr_d    = tx_data;
          rx_sr_d    = '0;
          mosi_d     = first_bit(tx_data, lsb_first);
          sclk_d     = cpol;
          cs_n_d     = decode_cs(cs_sel);
          edge_cnt_d = '0;
          state_d    = ST_SETUP;
        end else begin
          sclk_d     = cfg_q.cpol;
          cs_n_d     = {NUM_CS{1'b1}};
        end
      end
      ST_HOLD: begin
        // The held slave stays selected; only mode, order and data are refreshed.
        if (start) begin
          cfg_d      = cfg_in_s;
          tx_sr_d    = tx_data;
          rx_sr_d    = '0;
          mosi_d     = first_bit(tx_data, lsb_first);
          sclk_d     = cpol;
          edge_cnt_d = '0;
          state_d    = ST_SETUP;
        end else if (cs_release) begin
          cs_n_d     = {NUM_CS{1'b1}};
          state_d    = ST_GAP;
        end else begin
          state_d    = ST_HOLD;
        end
      end
      ST_SETUP: begin
        if (tick_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        if (tick_s) begin
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + ECW'(1);
          if (lead_s) begin
            // cpha=1 drives the first bit from setup, so edge 1 does not advance.
            if (!cfg_q.cpha) begin
              rx_sr_d = rx_shift_s;
            end else if (edge_cnt_q != '0) begin
              tx_sr_d = tx_next_s;
              mosi_d  = first_bit(tx_next_s, cfg_q.lsb_first);
            end else begin
              tx_sr_d = tx_sr_q;
            end
          end else begin
            if (cfg_q.cpha) begin
              rx_sr_d = rx_shift_s;
            end else if (!last_edge_s) begin
              tx_sr_d = tx_next_s;
              mosi_d  = first_bit(tx_next_s, cfg_q.lsb_first);
            end else begin
              tx_sr_d = tx_sr_q;
            end
          end
          if (last_edge_s) begin
            state_d = ST_TRAIL;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_TRAIL: begin
        if (tick_s) begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          if (cfg_q.hold_cs) begin
            state_d = ST_HOLD;
          end else begin
            cs_n_d  = {NUM_CS{1'b1}};
            state_d = ST_GAP;
          end
        end else begin
          state_d = ST_TRAIL;
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = {NUM_CS{1'b1}};
        sclk_d  = cfg_q.cpol;
      end
    endcase
    busy_d  = (state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
              (state_d == ST_TRAIL) || (state_d == ST_GAP);
    ready_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
  end

  // State and output registers; reset drops CS and parks SCLK low at once.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= {NUM_CS{1'b1}};
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign ready    = ready_q;
  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi at HALF=2, 8-bit words, 4 chip selects,
// plus a 5-select instance for the out-of-range select case.
module tb_spi_master_multi;

  logic       sys_clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic [1:0] cs_sel;
  logic       cpol, cpha, lsb_first, hold_cs, start, cs_release;
  logic [7:0] rx_data;
  logic       rx_valid, busy, ready, spi_sclk, spi_mosi, spi_miso;
  logic [3:0] spi_cs_n;

  logic [2:0] cs_sel5;
  logic       start5;
  logic [7:0] rx_data5;
  logic       rx_valid5, busy5, ready5, spi_sclk5, spi_mosi5;
  logic [4:0] spi_cs_n5;

  localparam logic [7:0] SLV_RESP = 8'h3C;
  logic       slave_en;
  logic       slave_miso;
  logic [2:0] s_idx;
  logic [7:0] s_rx;

  int n_checks;
  int n_err;
  int rx_cnt;
  int sclk_rises;
  logic [7:0] sb_q[$];

  assign spi_miso = slave_en ? slave_miso : spi_mosi;

  spi_master_multi #(
    .CLK_FREQ(50_000_000), .SPI_FREQ(12_500_000), .DATA_WIDTH(8), .NUM_CS(4)
  ) u_dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .tx_data(tx_data), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .hold_cs(hold_cs),
    .start(start), .cs_release(cs_release), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .ready(ready), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_master_multi #(
    .CLK_FREQ(50_000_000), .SPI_FREQ(12_500_000), .DATA_WIDTH(8), .NUM_CS(5)
  ) u_dut5 (
    .sys_clk(sys_clk), .rst_n(rst_n), .tx_data(tx_data), .cs_sel(cs_sel5),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .hold_cs(hold_cs),
    .start(start5), .cs_release(cs_release), .rx_data(rx_data5), .rx_valid(rx_valid5),
    .busy(busy5), .ready(ready5), .spi_sclk(spi_sclk5), .spi_cs_n(spi_cs_n5),
    .spi_mosi(spi_mosi5), .spi_miso(spi_mosi5)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every rx_valid pops the oldest expected word.
  always @(negedge sys_clk) begin
    if (rst_n && rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      if (sb_q.size() == 0) chk("sb_empty", 32'(sb_q.size()), 32'd1);
      else chk("rx_data", 32'(rx_data), 32'(sb_q.pop_front()));
    end
  end

  // SCLK rising-edge counter.
  always @(posedge spi_sclk) begin
    if (rst_n) sclk_rises <= sclk_rises + 1;
  end

  // Mode-3 LSB-first slave: drives on falling edges, captures on rising edges.
  always @(negedge spi_sclk) begin
    if (slave_en) begin
      slave_miso <= SLV_RESP[s_idx];
      s_idx      <= s_idx + 3'd1;
    end
  end
  always @(posedge spi_sclk) begin
    if (slave_en) s_rx <= {spi_mosi, s_rx[7:1]};
  end

  // Wait for ready, present one request for one cycle, queue the expected reply.
  task automatic do_start(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                          input logic pha, input logic lsb, input logic hold,
                          input logic [7:0] exp_rx);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("ready_before_start", 32'(ready), 32'd1);
    @(negedge sys_clk);
    tx_data = tx; cs_sel = sel; cpol = pol; cpha = pha; lsb_first = lsb; hold_cs = hold;
    start = 1'b1;
    sb_q.push_back(exp_rx);
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  // Count cycles from the accepting edge (counted as 1) until rx_valid, checking CS meanwhile.
  task automatic wait_rx(input logic [3:0] cs_exp, output int cyc, output int cs_bad);
    cyc = 1;
    cs_bad = 0;
    while (!rx_valid && cyc < 300) begin
      if (spi_cs_n !== cs_exp) cs_bad++;
      @(posedge sys_clk); #1;
      cyc++;
    end
    chk("rx_valid_seen", 32'(rx_valid), 32'd1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad, base, rx0;
    n_checks = 0; n_err = 0; rx_cnt = 0; sclk_rises = 0;
    slave_en = 1'b0; slave_miso = 1'b0; s_idx = 3'd0; s_rx = 8'h00;
    rst_n = 1'b0; tx_data = 8'h00; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; hold_cs = 1'b0; start = 1'b0; cs_release = 1'b0;
    cs_sel5 = 3'd0; start5 = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_cs_n", 32'(spi_cs_n), 32'hF);
    chk("rst_sclk", 32'(spi_sclk), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    @(negedge sys_clk) rst_n = 1'b1;

    // 1: loopback mode 0 MSB-first to slave 2
    base = sclk_rises;
    do_start(8'hA5, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
    chk("t1_cs_first", 32'(spi_cs_n), 32'hB);
    chk("t1_sclk_idle", 32'(spi_sclk), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_rx(4'b1011, cyc, bad);
    chk("t1_latency", 32'(cyc), 32'd37);
    chk("t1_cs_during", 32'(bad), 32'd0);
    chk("t1_sclk_pulses", 32'(sclk_rises - base), 32'd8);
    chk("t1_gap_cs_a", 32'(spi_cs_n), 32'hF);
    chk("t1_gap_busy", 32'(busy), 32'd1);
    @(posedge sys_clk); #1;
    chk("t1_gap_cs_b", 32'(spi_cs_n), 32'hF);
    chk("t1_gap_ready", 32'(ready), 32'd0);
    @(posedge sys_clk); #1;
    chk("t1_ready_back", 32'(ready), 32'd1);
    chk("t1_busy_off", 32'(busy), 32'd0);

    // 2: mode 3 LSB-first against the slave model
    slave_en = 1'b1;
    do_start(8'h81, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, SLV_RESP);
    chk("t2_sclk_idle_hi", 32'(spi_sclk), 32'd1);
    wait_rx(4'b1101, cyc, bad);
    chk("t2_cs_during", 32'(bad), 32'd0);
    chk("t2_slave_rx", 32'(s_rx), 32'h81);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("t2_sclk_rest_hi", 32'(spi_sclk), 32'd1);
    slave_en = 1'b0;

    // 3: burst with held CS, select ignored from HOLD, release and ignored start in GAP
    do_start(8'h11, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    wait_rx(4'b1101, cyc, bad);
    chk("t3_cs_w1", 32'(bad), 32'd0);
    @(posedge sys_clk); #1;
    chk("t3_hold_cs", 32'(spi_cs_n), 32'hD);
    chk("t3_hold_ready", 32'(ready), 32'd1);
    chk("t3_hold_busy", 32'(busy), 32'd0);
    do_start(8'h22, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
    wait_rx(4'b1101, cyc, bad);
    chk("t3_cs_w2", 32'(bad), 32'd0);
    @(posedge sys_clk); #1;
    chk("t3_hold2_cs", 32'(spi_cs_n), 32'hD);
    rx0 = rx_cnt;
    @(negedge sys_clk) cs_release = 1'b1;
    @(posedge sys_clk); #1;
    cs_release = 1'b0;
    chk("t3_release_cs", 32'(spi_cs_n), 32'hF);
    chk("t3_release_busy", 32'(busy), 32'd1);
    @(negedge sys_clk);
    tx_data = 8'h77; cs_sel = 2'd0; hold_cs = 1'b0; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (50) @(posedge sys_clk);
    #1;
    chk("t3_gap_start_ign", 32'(rx_cnt - rx0), 32'd0);
    chk("t3_idle_cs", 32'(spi_cs_n), 32'hF);
    chk("t3_idle_ready", 32'(ready), 32'd1);

    // 4: stray start mid-SHIFT and cs_release in IDLE do nothing
    rx0 = rx_cnt;
    do_start(8'h96, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h96);
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    tx_data = 8'hFF; cs_sel = 2'd0; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    wait_rx(4'b0111, cyc, bad);
    chk("t4_cs_during", 32'(bad), 32'd0);
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk) cs_release = 1'b1;
    @(posedge sys_clk); #1;
    cs_release = 1'b0;
    chk("t4_release_idle_cs", 32'(spi_cs_n), 32'hF);
    chk("t4_release_idle_busy", 32'(busy), 32'd0);
    chk("t4_release_idle_ready", 32'(ready), 32'd1);
    repeat (40) @(posedge sys_clk);
    #1;
    chk("t4_one_rx_valid", 32'(rx_cnt - rx0), 32'd1);

    // 5: async reset mid-transfer, then a clean transfer
    do_start(8'hC3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3);
    repeat (18) @(posedge sys_clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_cs", 32'(spi_cs_n), 32'hF);
    chk("t5_rst_sclk", 32'(spi_sclk), 32'd0);
    chk("t5_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("t5_rst_rx_data", 32'(rx_data), 32'd0);
    sb_q.delete();
    @(negedge sys_clk) rst_n = 1'b1;
    do_start(8'h3E, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3E);
    wait_rx(4'b1011, cyc, bad);
    chk("t5_cs_during", 32'(bad), 32'd0);

    // 6: out-of-range select on the 5-select instance
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    tx_data = 8'h5A; cs_sel5 = 3'd5; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    hold_cs = 1'b0; start5 = 1'b1;
    @(posedge sys_clk); #1;
    start5 = 1'b0;
    cyc = 1; bad = 0;
    while (!rx_valid5 && cyc < 300) begin
      if (spi_cs_n5 !== 5'h1F) bad++;
      @(posedge sys_clk); #1;
      cyc++;
    end
    chk("t6_rx_valid", 32'(rx_valid5), 32'd1);
    chk("t6_cs_high", 32'(bad), 32'd0);
    chk("t6_rx_data", 32'(rx_data5), 32'h5A);
    chk("t6_latency", 32'(cyc), 32'd37);

    repeat (5) @(posedge sys_clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
